// File: rtl/ro_packer_pkg.sv
// ro_packer_pkg
//   Shared digitizer definitions for the readout packer: FSM state
//   encodings and the default constants for word width, frame length,
//   idle timeout and the upper-half filler.
package ro_packer_pkg;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,   // waiting for the low half-word
        S_HI  = 2'd1,   // low half held, waiting for the high half-word
        S_OUT = 2'd2    // packed beat presented downstream
    } state_t;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_FRAME_BEATS = 64;
    localparam int unsigned DEF_TIMEOUT     = 255;
    localparam logic [15:0] DEF_PAD         = 16'hFFFF;

endpackage

// File: rtl/ro_timeout_ctr.sv
// ro_timeout_ctr
//   Up-counter with synchronous clear and enable that flags when it sits
//   at its terminal value TERM. Used for both idle timing and frame-beat
//   counting in the packer.
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   clr  in  synchronous clear (wins over en)
//   en   in  count enable
//   tc   out count == TERM
module ro_timeout_ctr #(
    parameter int unsigned W    = 8,
    parameter int unsigned TERM = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(TERM));

endmodule

// File: rtl/ro_packer.sv
// ro_packer
//   Pairs consecutive WIDTH-bit words from the global FIFO into one
//   2*WIDTH beat (first word in the low half) with a valid/ready output.
//   A lone low half is flushed with PAD in the upper half after TIMEOUT
//   idle cycles; such a beat always carries M_LAST. Frames are
//   FRAME_BEATS beats long.
//   CLK        in   sole clock
//   RST        in   synchronous active-high reset
//   FIFO_DOUT  in   FIFO read data, valid one cycle after FIFO_RD_EN
//   FIFO_EMPTY in   FIFO empty flag
//   FIFO_RD_EN out  single-cycle FIFO read strobe
//   M_DATA     out  packed beat
//   M_VALID    out  beat valid
//   M_READY    in   consumer accepts beat
//   M_LAST     out  last beat of frame (qualified by M_VALID)
//   BEAT_CNT   out  accepted beats since reset, wrapping
module ro_packer
    import ro_packer_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter int unsigned      FRAME_BEATS = DEF_FRAME_BEATS,
    parameter int unsigned      TIMEOUT     = DEF_TIMEOUT,
    parameter logic [WIDTH-1:0] PAD         = WIDTH'(DEF_PAD)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   FIFO_DOUT,
    input  logic               FIFO_EMPTY,
    output logic               FIFO_RD_EN,
    output logic [2*WIDTH-1:0] M_DATA,
    output logic               M_VALID,
    input  logic               M_READY,
    output logic               M_LAST,
    output logic [15:0]        BEAT_CNT
);

    localparam int unsigned IDLE_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned FRAME_W = (FRAME_BEATS < 2) ? 1 : $clog2(FRAME_BEATS);

    state_t           state, state_nxt;
    logic             pending;      // read strobe issued last cycle
    logic [WIDTH-1:0] lo_q, hi_q;
    logic             flush_q;      // current beat was produced by a timeout
    logic [15:0]      beat_cnt;
    logic             rd_en;
    logic             xfer;
    logic             flush;
    logic             idle_tc;
    logic             frame_tc;

    assign xfer  = (state == S_OUT) && M_READY;
    // Flush has priority over a read that would start this very cycle.
    assign flush = (state == S_HI) && !pending && idle_tc;
    assign rd_en = !RST && ((state == S_LO) || (state == S_HI))
                   && !FIFO_EMPTY && !pending && !flush;

    ro_timeout_ctr #(
        .W    (IDLE_W),
        .TERM (TIMEOUT)
    ) u_idle (
        .clk (CLK),
        .rst (RST),
        .clr ((state != S_HI) || pending || rd_en),
        .en  ((state == S_HI) && !pending && FIFO_EMPTY && !idle_tc),
        .tc  (idle_tc)
    );

    ro_timeout_ctr #(
        .W    (FRAME_W),
        .TERM (FRAME_BEATS - 1)
    ) u_frame (
        .clk (CLK),
        .rst (RST),
        .clr (xfer && M_LAST),
        .en  (xfer),
        .tc  (frame_tc)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LO:    if (pending) state_nxt = S_HI;
            S_HI:    if (pending || flush) state_nxt = S_OUT;
            S_OUT:   if (M_READY) state_nxt = S_LO;
            default: state_nxt = S_LO;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_LO;
            pending  <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            flush_q  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pending  <= rd_en;
            // Unconditional update keeps the counter a plain accumulator.
            beat_cnt <= beat_cnt + 16'(xfer);
            if (pending && (state == S_LO)) begin
                lo_q <= FIFO_DOUT;
            end
            if (pending && (state == S_HI)) begin
                hi_q <= FIFO_DOUT;
            end else if (flush) begin
                hi_q <= PAD;
            end
            if (xfer) begin
                flush_q <= 1'b0;
            end else if (flush) begin
                flush_q <= 1'b1;
            end
        end
    end

    assign FIFO_RD_EN = rd_en;
    assign M_DATA     = {hi_q, lo_q};
    assign M_VALID    = (state == S_OUT);
    assign M_LAST     = (state == S_OUT) && (frame_tc || flush_q);
    assign BEAT_CNT   = beat_cnt;

endmodule

// File: tb/tb_ro_packer.sv
// tb_ro_packer
//   Directed bench for ro_packer (FRAME_BEATS=4, other parameters at
//   default) with a small behavioural model of the global FIFO.
module tb_ro_packer;

    logic        CLK;
    logic        RST;
    logic [15:0] FIFO_DOUT = '0;
    logic        FIFO_EMPTY;
    logic        FIFO_RD_EN;
    logic [31:0] M_DATA;
    logic        M_VALID;
    logic        M_READY;
    logic        M_LAST;
    logic [15:0] BEAT_CNT;

    int n_vec = 0;
    int n_bad = 0;

    ro_packer #(
        .FRAME_BEATS (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FIFO_DOUT  (FIFO_DOUT),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RD_EN (FIFO_RD_EN),
        .M_DATA     (M_DATA),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_LAST     (M_LAST),
        .BEAT_CNT   (BEAT_CNT)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // Global FIFO model: registered read data, one cycle after the strobe.
    logic [15:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    assign FIFO_EMPTY = (wp == rp);

    always @(posedge CLK) begin
        if (FIFO_RD_EN) begin
            FIFO_DOUT <= mem[rp[5:0]];
            rp <= rp + 1;
        end
    end

    task automatic push(input logic [15:0] w);
        mem[wp[5:0]] = w;
        wp = wp + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!M_VALID && cyc < 400);
    endtask

    function automatic logic [15:0] fw(input int i);
        return (i == 0) ? 16'h3333 : 16'(16'h0100 + i);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] hold;
        logic        seen;

        RST     = 1'b1;
        M_READY = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_rd_en",    FIFO_RD_EN, 0);
        chk("rst_valid",    M_VALID,    0);
        chk("rst_last",     M_LAST,     0);
        chk("rst_data",     M_DATA,     0);
        chk("rst_beat_cnt", BEAT_CNT,   0);

        // Pairing; words queued while still in reset must not be read.
        push(16'h1111);
        push(16'h2222);
        #1 chk("rst_rd_gated", FIFO_RD_EN, 0);
        @(negedge CLK);
        RST = 1'b0;
        wait_valid(cyc);
        chk("pair_latency", cyc, 4);
        chk("pair_data", M_DATA, 32'h2222_1111);
        chk("pair_last", M_LAST, 0);
        @(negedge CLK);
        chk("pair_beat_cnt", BEAT_CNT, 1);
        chk("pair_valid_drop", M_VALID, 0);

        // Flush: read at cycle 0, S_HI from cycle 2, idle count hits 255 in
        // cycle 257, beat valid in cycle 258. A word arriving in the timeout
        // cycle must not be read.
        push(16'hABCD);
        for (int c = 1; c <= 257; c++) @(negedge CLK);
        chk("flush_early", M_VALID, 0);
        push(16'h3333);
        #1 chk("flush_prio_no_rd", FIFO_RD_EN, 0);
        @(negedge CLK);
        chk("flush_valid", M_VALID, 1);
        chk("flush_data", M_DATA, 32'hFFFF_ABCD);
        chk("flush_last", M_LAST, 1);
        chk("flush_no_rd_out", FIFO_RD_EN, 0);
        @(negedge CLK);
        chk("flush_beat_cnt", BEAT_CNT, 2);

        // Frame boundary: 16 words (0x3333 already queued), 8 beats,
        // M_LAST on the 4th and 8th.
        for (int i = 1; i < 16; i++) push(fw(i));
        for (int b = 0; b < 8; b++) begin
            wait_valid(cyc);
            chk("frame_valid", M_VALID, 1);
            chk("frame_data", M_DATA, {fw(2 * b + 1), fw(2 * b)});
            chk("frame_last", M_LAST, ((b % 4) == 3) ? 1 : 0);
        end
        @(negedge CLK);
        chk("frame_beat_cnt", BEAT_CNT, 10);

        // Backpressure: beat held 10 cycles while more words wait in the FIFO.
        M_READY = 1'b0;
        push(16'hBEEF);
        push(16'hCAFE);
        wait_valid(cyc);
        chk("bp_valid", M_VALID, 1);
        chk("bp_data", M_DATA, 32'hCAFE_BEEF);
        hold = M_DATA;
        push(16'h7777);
        push(16'h8888);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("bp_hold_data", M_DATA, hold);
            chk("bp_hold_valid", M_VALID, 1);
            seen = seen | FIFO_RD_EN;
        end
        chk("bp_no_rd", seen, 0);
        chk("bp_last", M_LAST, 0);
        chk("bp_beat_cnt_held", BEAT_CNT, 10);
        M_READY = 1'b1;
        @(negedge CLK);
        chk("bp_beat_cnt", BEAT_CNT, 11);
        chk("bp_valid_drop", M_VALID, 0);
        wait_valid(cyc);
        chk("bp_next_data", M_DATA, 32'h8888_7777);
        chk("bp_next_last", M_LAST, 0);
        @(negedge CLK);
        chk("bp_next_beat_cnt", BEAT_CNT, 12);

        // Reset mid-beat: low half held, a read in flight when reset hits.
        push(16'h5555);
        repeat (10) @(negedge CLK);
        chk("mid_held_no_beat", M_VALID, 0);
        push(16'h9999);
        @(negedge CLK);
        RST = 1'b1;
        #1 chk("mid_rst_rd_en", FIFO_RD_EN, 0);
        @(negedge CLK);
        chk("mid_rst_beat_cnt", BEAT_CNT, 0);
        chk("mid_rst_data", M_DATA, 0);
        chk("mid_rst_valid", M_VALID, 0);
        @(negedge CLK);
        RST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            seen = seen | M_VALID;
        end
        chk("mid_no_beat", seen, 0);
        push(16'h0001);
        push(16'h0002);
        wait_valid(cyc);
        chk("mid_data", M_DATA, 32'h0002_0001);
        chk("mid_last", M_LAST, 0);
        @(negedge CLK);
        chk("mid_beat_cnt", BEAT_CNT, 1);

        // Wrap: counter preloaded to 65535, as after 65535 transfers.
        force dut.beat_cnt = 16'hFFFF;
        @(negedge CLK);
        release dut.beat_cnt;
        #1 chk("wrap_preload", BEAT_CNT, 16'hFFFF);
        push(16'h00A1);
        push(16'h00A2);
        wait_valid(cyc);
        chk("wrap_data", M_DATA, 32'h00A2_00A1);
        @(negedge CLK);
        chk("wrap_zero", BEAT_CNT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
